// File: rtl/regfile_pkg.sv
// Shared types and sizes for the register-file sequencer.
`timescale 1ns/1ps
package regfile_pkg;
   localparam int NREG = 8;
   localparam int DW   = 10;
   localparam int AW   = $clog2(NREG);

   typedef enum logic [1:0] {OP_LOAD, OP_MOV, OP_ALU, OP_DISP} opc_e;
   typedef enum logic [1:0] {FN_ADD, FN_SUB, FN_AND, FN_XOR}   alu_fn_e;
   typedef enum logic [1:0] {DSEL_DIN, DSEL_Q1, DSEL_G}        dsel_e;
   typedef enum logic [1:0] {S_IDLE, S_READ, S_EXEC, S_WRITE}  state_e;
endpackage

// File: rtl/regfile_ctrl.sv
// Multi-cycle sequencer driving the 8x10 register file and ALU from one instruction at a time.
// Optional retire counter output when REGCTL_RETIRE_CNT_EN is defined.
//
// state   | meaning
// S_IDLE  | ready for a new instruction
// S_READ  | read ports addressed (MOV/ALU operands, DISP output)
// S_EXEC  | ALU captures operands and result
// S_WRITE | register-file write, instruction retires
`timescale 1ns/1ps
module regfile_ctrl
   import regfile_pkg::*;
(
   input  logic          CLKb,
   input  logic          RSTb,
   input  logic [DW-1:0] instr,
   input  logic          instr_vld,
   output logic          instr_rdy,
   output logic [AW-1:0] WRA,
   output logic [AW-1:0] RDA0,
   output logic [AW-1:0] RDA1,
   output logic          ENW,
   output logic          ENR0,
   output logic [1:0]    alu_op,
   output logic          alu_ld,
   output logic [1:0]    d_sel,
`ifdef REGCTL_RETIRE_CNT_EN
   output logic [15:0]   retire_cnt,
`endif
   output logic          done
);

   state_e        state, state_nxt;
   logic [DW-1:0] ir;
   opc_e          ir_opc;
   logic [AW-1:0] ir_rx, ir_ry;
   alu_fn_e       ir_fn;

   assign ir_opc = opc_e'(ir[9:8]);
   assign ir_rx  = ir[7:5];
   assign ir_ry  = ir[4:2];
   assign ir_fn  = alu_fn_e'(ir[1:0]);

   always_ff @(posedge CLKb or negedge RSTb) begin
      if (!RSTb) begin
         state <= S_IDLE;
         ir    <= '0;
      end else begin
         state <= state_nxt;
         if (state == S_IDLE && instr_vld)
            ir <= instr;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: begin
            if (instr_vld)
               state_nxt = (opc_e'(instr[9:8]) == OP_LOAD) ? S_WRITE : S_READ;
         end
         S_READ: begin
            case (ir_opc)
               OP_ALU:  state_nxt = S_EXEC;
               OP_MOV:  state_nxt = S_WRITE;
               default: state_nxt = S_IDLE;
            endcase
         end
         S_EXEC:  state_nxt = S_WRITE;
         S_WRITE: state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // Outputs decode only the state and IR, so nothing combinational reaches them from instr.
   always_comb begin
      instr_rdy = 1'b0;
      WRA       = '0;
      RDA0      = '0;
      RDA1      = '0;
      ENW       = 1'b0;
      ENR0      = 1'b0;
      alu_op    = 2'd0;
      alu_ld    = 1'b0;
      d_sel     = DSEL_DIN;
      done      = 1'b0;
      case (state)
         S_IDLE: instr_rdy = 1'b1;
         S_READ: begin
            case (ir_opc)
               OP_MOV: RDA1 = ir_ry;
               OP_ALU: begin
                  ENR0 = 1'b1;
                  RDA0 = ir_rx;
                  RDA1 = ir_ry;
               end
               OP_DISP: begin
                  ENR0 = 1'b1;
                  RDA0 = ir_rx;
                  done = 1'b1;
               end
               default: ;
            endcase
         end
         S_EXEC: begin
            // Q0 stays driven so the ALU sees both operands while it loads.
            ENR0   = 1'b1;
            RDA0   = ir_rx;
            RDA1   = ir_ry;
            alu_ld = 1'b1;
            alu_op = ir_fn;
         end
         S_WRITE: begin
            ENW  = 1'b1;
            WRA  = ir_rx;
            done = 1'b1;
            case (ir_opc)
               OP_MOV: begin
                  RDA1  = ir_ry;
                  d_sel = DSEL_Q1;
               end
               OP_ALU:  d_sel = DSEL_G;
               default: d_sel = DSEL_DIN;
            endcase
         end
         default: ;
      endcase
   end

`ifdef REGCTL_RETIRE_CNT_EN
   always_ff @(posedge CLKb or negedge RSTb) begin
      if (!RSTb)
         retire_cnt <= '0;
      else if (done)
         retire_cnt <= retire_cnt + 16'd1;
   end
`endif

endmodule

// File: tb/tb_regfile_ctrl.sv
// Self-checking bench for regfile_ctrl: directed vectors, corner sequences and random instructions.
`timescale 1ns/1ps
module tb_regfile_ctrl;
   logic       CLKb = 1'b0;
   logic       RSTb;
   logic [9:0] instr;
   logic       instr_vld;
   logic       instr_rdy, ENW, ENR0, alu_ld, done;
   logic [2:0] WRA, RDA0, RDA1;
   logic [1:0] alu_op, d_sel;
`ifdef REGCTL_RETIRE_CNT_EN
   logic [15:0] retire_cnt;
`endif

   regfile_ctrl dut (
      .CLKb(CLKb), .RSTb(RSTb), .instr(instr), .instr_vld(instr_vld),
      .instr_rdy(instr_rdy), .WRA(WRA), .RDA0(RDA0), .RDA1(RDA1),
      .ENW(ENW), .ENR0(ENR0), .alu_op(alu_op), .alu_ld(alu_ld), .d_sel(d_sel),
`ifdef REGCTL_RETIRE_CNT_EN
      .retire_cnt(retire_cnt),
`endif
      .done(done)
   );

   always #5 CLKb = ~CLKb;

   typedef struct packed {
      logic       rdy;
      logic [2:0] wra, rda0, rda1;
      logic       enw, enr0;
      logic [1:0] op;
      logic       ld;
      logic [1:0] dsel;
      logic       done;
   } outs_t;

   typedef struct {
      logic [9:0] ins;
      int         lat;
      logic [2:0] wra;
      logic [1:0] dsel;
      logic       enw;
   } vec_t;

   int checks = 0;
   int errors = 0;
   int retire_m = 0;

   function automatic outs_t sample();
      return {instr_rdy, WRA, RDA0, RDA1, ENW, ENR0, alu_op, alu_ld, d_sel, done};
   endfunction

   function automatic int lat_of(logic [9:0] i);
      case (i[9:8])
         2'd0: return 1;
         2'd1: return 2;
         2'd2: return 3;
         default: return 1;
      endcase
   endfunction

   // Expected outputs for phase p cycles after acceptance; p < 0 means idle.
   function automatic outs_t model(logic [9:0] i, int p);
      outs_t o = '0;
      logic [2:0] rx = i[7:5];
      logic [2:0] ry = i[4:2];
      if (p < 0) begin
         o.rdy = 1'b1;
         return o;
      end
      case (i[9:8])
         2'd0: begin o.enw = 1; o.wra = rx; o.dsel = 2'd0; o.done = 1; end
         2'd1: begin
            o.rda1 = ry;
            if (p == 1) begin o.enw = 1; o.wra = rx; o.dsel = 2'd1; o.done = 1; end
         end
         2'd2: begin
            if (p == 0) begin o.enr0 = 1; o.rda0 = rx; o.rda1 = ry; end
            else if (p == 1) begin o.rda0 = rx; o.rda1 = ry; o.ld = 1; o.op = i[1:0]; end
            else begin o.enw = 1; o.wra = rx; o.dsel = 2'd2; o.done = 1; end
         end
         default: begin o.enr0 = 1; o.rda0 = rx; o.done = 1; end
      endcase
      return o;
   endfunction

   task automatic chk(input string name, input outs_t act, input outs_t exp, input outs_t mask);
      checks++;
      if (((act ^ exp) & mask) != '0) begin
         errors++;
         $display("FAIL %s: got %h expected %h (mask %h) at %0t", name, act, exp, mask, $time);
      end
   endtask

   task automatic chk_int(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Starts just after a falling edge with the DUT idle; ends the same way.
   task automatic run_instr(input logic [9:0] i, output int done_at, output outs_t done_o);
      int lat = lat_of(i);
      outs_t o, e, m;
      done_at = 0;
      done_o  = '0;
      instr = i;
      instr_vld = 1'b1;
      #1;
      chk("idle", sample(), model(i, -1), '1);
      @(posedge CLKb);
      @(negedge CLKb);
      for (int p = 0; p < lat; p++) begin
         instr_vld = 1'($urandom_range(0, 1));
         instr = 10'($urandom_range(0, 1023));
         #1;
         o = sample();
         e = model(i, p);
         m = '1;
         if (i[9:8] == 2'd2 && p == 1) m.enr0 = 1'b0;
         chk("phase", o, e, m);
         if (e.done) retire_m++;
         if (o.done && done_at == 0) begin
            done_at = p + 1;
            done_o  = o;
         end
         @(negedge CLKb);
      end
      instr_vld = 1'b0;
   endtask

   initial begin
      vec_t  vecs[6];
      outs_t rmask, dout;
      int    dat;
      int    dtimes[$];
      int    ndone;

      vecs[0] = '{10'b00_011_000_00, 1, 3'd3, 2'd0, 1'b1};
      vecs[1] = '{10'b01_101_010_00, 2, 3'd5, 2'd1, 1'b1};
      vecs[2] = '{10'b10_001_100_01, 3, 3'd1, 2'd2, 1'b1};
      vecs[3] = '{10'b11_110_000_00, 1, 3'd0, 2'd0, 1'b0};
      vecs[4] = '{10'b10_111_111_11, 3, 3'd7, 2'd2, 1'b1};
      vecs[5] = '{10'b00_000_101_10, 1, 3'd0, 2'd0, 1'b1};

      rmask = '1;
      rmask.rdy = 1'b0;

      RSTb = 1'b0;
      instr = '0;
      instr_vld = 1'b0;
      #12;
      chk("reset_outs", sample(), '0, rmask);
      @(negedge CLKb);
      RSTb = 1'b1;
      #1;
      chk("post_reset_idle", sample(), model('0, -1), '1);
      @(negedge CLKb);

      foreach (vecs[k]) begin
         run_instr(vecs[k].ins, dat, dout);
         chk_int("vec_latency", dat, vecs[k].lat);
         chk_int("vec_wra", int'(dout.wra), int'(vecs[k].wra));
         chk_int("vec_dsel", int'(dout.dsel), int'(vecs[k].dsel));
         chk_int("vec_enw", int'(dout.enw), int'(vecs[k].enw));
      end

      // Valid held high across three ALU instructions.
      instr = 10'b10_010_011_10;
      instr_vld = 1'b1;
      ndone = 0;
      for (int c = 0; c < 16; c++) begin
         @(negedge CLKb);
         #1;
         if (done) begin
            dtimes.push_back(c);
            ndone++;
            if (ndone == 3) instr_vld = 1'b0;
         end
      end
      retire_m += 3;
      chk_int("b2b_done_count", dtimes.size(), 3);
      if (dtimes.size() >= 3) begin
         chk_int("b2b_spacing1", dtimes[1] - dtimes[0], 4);
         chk_int("b2b_spacing2", dtimes[2] - dtimes[1], 4);
      end
      chk("b2b_idle_after", sample(), model('0, -1), '1);
      @(negedge CLKb);

      // Reset asserted while the ALU is in its execute cycle.
      instr = 10'b10_100_001_00;
      instr_vld = 1'b1;
      @(posedge CLKb);
      @(negedge CLKb);
      instr_vld = 1'b0;
      @(negedge CLKb);
      #1;
      chk_int("pre_reset_exec_ld", int'(alu_ld), 1);
      RSTb = 1'b0;
      #1;
      chk("reset_mid_exec", sample(), '0, rmask);
      @(negedge CLKb);
      chk("reset_held", sample(), '0, rmask);
      RSTb = 1'b1;
      #1;
      chk("after_reset_rdy", sample(), model('0, -1), '1);
      @(negedge CLKb);
      chk("no_stale_ir", sample(), model('0, -1), '1);
      run_instr(10'b00_110_000_00, dat, dout);
      chk_int("post_reset_load_lat", dat, 1);

      for (int n = 0; n < 60; n++)
         run_instr(10'($urandom_range(0, 1023)), dat, dout);

`ifdef REGCTL_RETIRE_CNT_EN
      chk_int("retire_cnt", int'(retire_cnt), retire_m % 65536);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end
endmodule
